// File: rtl/cplx_pkg.sv
// Shared definitions for the complex-ALU sequencer: FSM states, opcode and
// write-endianness codes, and the width of the EXEC watchdog counter.
package cplx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_LAUNCH = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    localparam int OP_MOVE = 0;

    localparam logic [1:0] ENDW_64 = 2'b00;
    localparam logic [1:0] ENDW_32 = 2'b01;
    localparam logic [1:0] ENDW_16 = 2'b10;
    localparam logic [1:0] ENDW_8  = 2'b11;

    localparam int TMR_W = 8;

endpackage

// File: rtl/seq_timer.sv
// EXEC watchdog: cleared by load, counts enabled cycles, and flags expire
// during the TIMEOUT-th enabled cycle.
module seq_timer
    import cplx_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/cplx_seq_ctrl.sv
// Command sequencer: reads two operands from the register bank, runs them
// through the complex ALU (or moves A directly) and writes the result back.
module cplx_seq_ctrl
    import cplx_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int OP_W    = 3
) (
    input  logic            clock,
    input  logic            reset,
    // cmd: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both high; cmd_ready is only high in IDLE, so fields are never
    // sampled while an operation is in flight.
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [3:0]      cmd_srcA,
    input  logic            cmd_cnstA,
    input  logic [3:0]      cmd_srcB,
    input  logic            cmd_cnstB,
    input  logic [3:0]      cmd_dst,
    input  logic [1:0]      cmd_endw,
    output logic [3:0]      rb_seloutA,
    output logic [3:0]      rb_seloutB,
    output logic            rb_cnstA,
    output logic            rb_cnstB,
    output logic            rb_enrregA,
    output logic            rb_enrregB,
    input  logic [63:0]     rb_outA,
    input  logic [63:0]     rb_outB,
    output logic            rb_regwen,
    output logic [3:0]      rb_selwreg,
    output logic [1:0]      rb_endwreg,
    output logic [63:0]     rb_inA,
    output logic            alu_start,
    output logic [OP_W-1:0] alu_op,
    output logic [63:0]     alu_opA,
    output logic [63:0]     alu_opB,
    input  logic            alu_done,
    input  logic [63:0]     alu_result,
    output logic            busy,
    output logic            op_done,
    output logic            err_timeout,
    output logic [2:0]      dbg_state
);

    state_t     state;
    logic [3:0] dst_q;
    logic [1:0] endw_q;
    logic       tmr_load;
    logic       tmr_en;
    logic       tmr_expire;

    assign tmr_load  = (state == S_LAUNCH);
    assign tmr_en    = (state == S_EXEC);
    assign dbg_state = state;

    seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (tmr_load),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b0;
            dst_q       <= '0;
            endw_q      <= '0;
            rb_seloutA  <= '0;
            rb_seloutB  <= '0;
            rb_cnstA    <= 1'b0;
            rb_cnstB    <= 1'b0;
            rb_enrregA  <= 1'b0;
            rb_enrregB  <= 1'b0;
            rb_regwen   <= 1'b0;
            rb_selwreg  <= '0;
            rb_endwreg  <= '0;
            rb_inA      <= '0;
            alu_start   <= 1'b0;
            alu_op      <= '0;
            alu_opA     <= '0;
            alu_opB     <= '0;
            busy        <= 1'b0;
            op_done     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Strobes are single-cycle; each state re-asserts what it needs.
            rb_enrregA <= 1'b0;
            rb_enrregB <= 1'b0;
            alu_start  <= 1'b0;
            rb_regwen  <= 1'b0;
            op_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_op      <= cmd_op;
                        dst_q       <= cmd_dst;
                        endw_q      <= cmd_endw;
                        rb_seloutA  <= cmd_srcA;
                        rb_seloutB  <= cmd_srcB;
                        rb_cnstA    <= cmd_cnstA;
                        rb_cnstB    <= cmd_cnstB;
                        rb_enrregA  <= 1'b1;
                        rb_enrregB  <= 1'b1;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        cmd_ready   <= 1'b0;
                        state       <= S_READ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    // Bank read data is valid in this cycle only.
                    alu_opA <= rb_outA;
                    alu_opB <= rb_outB;
                    if (alu_op == OP_W'(OP_MOVE)) begin
                        rb_inA     <= rb_outA;
                        rb_regwen  <= 1'b1;
                        rb_selwreg <= dst_q;
                        rb_endwreg <= endw_q;
                        op_done    <= 1'b1;
                        state      <= S_WRITE;
                    end else begin
                        alu_start <= 1'b1;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A done arriving in the expiry cycle still completes normally.
                    if (alu_done) begin
                        rb_inA     <= alu_result;
                        rb_regwen  <= 1'b1;
                        rb_selwreg <= dst_q;
                        rb_endwreg <= endw_q;
                        op_done    <= 1'b1;
                        state      <= S_WRITE;
                    end else if (tmr_expire) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_seq_ctrl.sv
// Randomized bench for cplx_seq_ctrl with a behavioural register bank and ALU,
// a per-command timing model and a write scoreboard.
module tb_cplx_seq_ctrl;

    localparam int OP_W = 3;
    localparam int TMO  = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OP_W-1:0] cmd_op;
    logic [3:0]      cmd_srcA, cmd_srcB, cmd_dst;
    logic            cmd_cnstA, cmd_cnstB;
    logic [1:0]      cmd_endw;
    logic [3:0]      rb_seloutA, rb_seloutB, rb_selwreg;
    logic            rb_cnstA, rb_cnstB, rb_enrregA, rb_enrregB, rb_regwen;
    logic [63:0]     rb_outA, rb_outB, rb_inA;
    logic [1:0]      rb_endwreg;
    logic            alu_start, alu_done;
    logic [OP_W-1:0] alu_op;
    logic [63:0]     alu_opA, alu_opB, alu_result;
    logic            busy, op_done, err_timeout;
    logic [2:0]      dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] seed;
    logic [63:0] ref_mem [16];
    logic [63:0] bank_mem [16];
    logic [15:0] bank_wr = '0;
    logic [69:0] exp_q [$];

    cplx_seq_ctrl #(.TIMEOUT(TMO), .OP_W(OP_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_srcA(cmd_srcA), .cmd_cnstA(cmd_cnstA), .cmd_srcB(cmd_srcB),
        .cmd_cnstB(cmd_cnstB), .cmd_dst(cmd_dst), .cmd_endw(cmd_endw),
        .rb_seloutA(rb_seloutA), .rb_seloutB(rb_seloutB), .rb_cnstA(rb_cnstA),
        .rb_cnstB(rb_cnstB), .rb_enrregA(rb_enrregA), .rb_enrregB(rb_enrregB),
        .rb_outA(rb_outA), .rb_outB(rb_outB), .rb_regwen(rb_regwen),
        .rb_selwreg(rb_selwreg), .rb_endwreg(rb_endwreg), .rb_inA(rb_inA),
        .alu_start(alu_start), .alu_op(alu_op), .alu_opA(alu_opA),
        .alu_opB(alu_opB), .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .op_done(op_done), .err_timeout(err_timeout),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    function automatic logic [63:0] init_val(input int i);
        case (i)
            1:       return 64'h4;
            2:       return 64'h6;
            3:       return 64'h0000_0005_0000_0002;
            default: return {seed ^ 32'(i * 32'h9E37_79B9), 32'(i) + 32'h1234_0000};
        endcase
    endfunction

    function automatic logic [63:0] cnst_val(input logic [3:0] sel);
        return 64'h100 + 64'(sel);
    endfunction

    function automatic logic [63:0] alu_fn(input int op, input logic [63:0] a, input logic [63:0] b);
        if (op == 1) return a + b;
        return a ^ (b + 64'(op));
    endfunction

    // Register bank: registered reads, full-width writes.
    always @(posedge clock) begin
        if (rb_enrregA)
            rb_outA <= rb_cnstA ? cnst_val(rb_seloutA) : (bank_wr[rb_seloutA] ? bank_mem[rb_seloutA] : init_val(int'(rb_seloutA)));
        if (rb_enrregB)
            rb_outB <= rb_cnstB ? cnst_val(rb_seloutB) : (bank_wr[rb_seloutB] ? bank_mem[rb_seloutB] : init_val(int'(rb_seloutB)));
        if (rb_regwen) begin
            bank_mem[rb_selwreg] <= rb_inA;
            bank_wr[rb_selwreg]  <= 1'b1;
        end
    end

    assign alu_result = alu_done ? alu_fn(int'(alu_op), alu_opA, alu_opB) : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (rb_regwen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(rb_selwreg), 64'hFFFF);
            end else begin
                check("write_data", 64'({rb_selwreg, rb_endwreg}), 64'(exp_q[0][69:64]));
                check("write_value", rb_inA, exp_q[0][63:0]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_zero(input string tag);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd0);
        check({tag, "_strobes"}, 64'({rb_enrregA, rb_enrregB, alu_start, rb_regwen, op_done}), 64'd0);
        check({tag, "_status"}, 64'({busy, err_timeout, dbg_state}), 64'd0);
        check({tag, "_sel"}, 64'({rb_seloutA, rb_seloutB, rb_selwreg, rb_endwreg, rb_cnstA, rb_cnstB, alu_op}), 64'd0);
        check({tag, "_data"}, alu_opA | alu_opB | rb_inA, 64'd0);
    endtask

    // Issue one command (entered and left at a negedge in IDLE) and check every
    // cycle against the timing derived from its op and ALU latency k (0 = never).
    task automatic run_cmd(input int op, input logic [3:0] sa, input logic ca,
                           input logic [3:0] sb, input logic cb, input logic [3:0] dst,
                           input logic [1:0] endw, input int k, input bit hold);
        logic [63:0] va, vb, res;
        bit to;
        int wc, end_c, exec_last;
        va = ca ? cnst_val(sa) : ref_mem[sa];
        vb = cb ? cnst_val(sb) : ref_mem[sb];
        res = (op == 0) ? va : alu_fn(op, va, vb);
        to = (op != 0) && (k == 0 || k > TMO);
        wc = (op == 0) ? 3 : 3 + k;
        end_c = to ? 3 + TMO : wc + 1;
        exec_last = to ? 2 + TMO : 2 + k;
        if (!to) begin
            exp_q.push_back({dst, endw, res});
            ref_mem[dst] = res;
        end
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_op = OP_W'(op); cmd_srcA = sa; cmd_cnstA = ca; cmd_srcB = sb;
        cmd_cnstB = cb; cmd_dst = dst; cmd_endw = endw; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) cmd_valid = 1'b0;
        for (int c = 1; c <= end_c; c++) begin
            alu_done = (op != 0) && (k != 0) && (c == 2 + k);
            check($sformatf("strobes_c%0d", c),
                  64'({rb_enrregA, rb_enrregB, alu_start, rb_regwen, op_done}),
                  64'({c == 1, c == 1, op != 0 && c == 3, !to && c == wc, !to && c == wc}));
            check($sformatf("status_c%0d", c), 64'({busy, cmd_ready, err_timeout}),
                  64'({c < end_c, c == end_c, c == end_c && to}));
            check("enr_regwen_overlap", 64'(rb_regwen & (rb_enrregA | rb_enrregB)), 64'd0);
            if (c == 1)
                check("read_sel", 64'({rb_seloutA, rb_cnstA, rb_seloutB, rb_cnstB}), 64'({sa, ca, sb, cb}));
            if (op != 0 && c >= 3 && c <= exec_last) begin
                check("alu_op", 64'(alu_op), 64'(op));
                check("alu_opA", alu_opA, va);
                check("alu_opB", alu_opB, vb);
            end
            if (c < end_c) @(negedge clock);
        end
        alu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        seed = $urandom;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_srcA = '0; cmd_srcB = '0;
        cmd_cnstA = 1'b0; cmd_cnstB = 1'b0; cmd_dst = '0; cmd_endw = '0; alu_done = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_zero("por");
        reset = 1'b0;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 5) begin
            @(negedge clock);
            n++;
        end
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        run_cmd(0, 4'd3, 1'b0, 4'd0, 1'b0, 4'd7, 2'b00, 0, 1'b0);  // MOVE r3 -> r7
        run_cmd(1, 4'd1, 1'b0, 4'd2, 1'b0, 4'd9, 2'b01, 4, 1'b0);  // ALU done in 4th EXEC cycle
        run_cmd(2, 4'd5, 1'b0, 4'd6, 1'b0, 4'd10, 2'b00, 0, 1'b0); // timeout
        run_cmd(1, 4'd3, 1'b0, 4'd4, 1'b1, 4'd11, 2'b10, TMO, 1'b0); // done on last cycle
        run_cmd(0, 4'd9, 1'b0, 4'd0, 1'b0, 4'd12, 2'b11, 0, 1'b1);  // back-to-back
        run_cmd(3, 4'd12, 1'b0, 4'd7, 1'b0, 4'd13, 2'b00, 2, 1'b1);
        run_cmd(0, 4'd13, 1'b0, 4'd0, 1'b0, 4'd14, 2'b00, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of EXEC must abort without a write.
        cmd_op = 3'd4; cmd_srcA = 4'd1; cmd_srcB = 4'd2; cmd_dst = 4'd15; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("exec_busy_before_reset", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_zero("mid_reset");
        @(negedge clock);
        check("regwen_in_reset", 64'(rb_regwen), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_mid_reset", 64'({cmd_ready, rb_regwen, busy}), 64'b100);
        run_cmd(0, 4'd15, 1'b0, 4'd0, 1'b0, 4'd8, 2'b00, 0, 1'b0);

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
